// File: rtl/dibu_pkg.sv
// rtl/dibu_pkg.sv - shared opcodes, flag indices and FSM encoding for the DiBU datapath
package dibu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MOV = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;

    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_N = 2;
    localparam int FLG_V = 3;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } exec_state_t;

endpackage

// File: rtl/alu_exec_mul_seq.sv
// rtl/alu_exec_mul_seq.sv - 8-iteration shift-add unsigned multiplier
module mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] partial;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               running;

    // product includes the current iteration's partial so the final sum is
    // available on the same edge that retires the last iteration
    assign partial = mplier[0] ? mcand : '0;
    assign product = acc + partial;
    assign done    = running && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (go) begin
            mcand   <= {{WIDTH{1'b0}}, a};
            mplier  <= b;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - DiBU execute stage: single-cycle ALU plus sequential multiply
module alu_exec
    import dibu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int RIDX  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [RIDX-1:0]   ri_dst,
    output logic              busy,
    output logic              rw,
    output logic [RIDX-1:0]   ri_d,
    output logic [WIDTH-1:0]  d,
    output logic [3:0]        flags,
    output logic              illegal
);

    exec_state_t          state, state_n;
    logic                 rw_n;
    logic [RIDX-1:0]      ri_d_n;
    logic [WIDTH-1:0]     d_n;
    logic [3:0]           flags_n;
    logic                 illegal_n;
    logic [RIDX-1:0]      mul_dst, mul_dst_n;
    logic                 mul_go;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_product;

    logic [WIDTH:0]       sum_w;
    logic [WIDTH:0]       diff_w;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c;
    logic                 alu_v;
    logic [3:0]           alu_flags;
    logic [3:0]           mul_flags;

    mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .go      (mul_go),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    assign sum_w  = {1'b0, a} + {1'b0, b};
    assign diff_w = {1'b0, a} - {1'b0, b};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = diff_w[WIDTH-1:0];
                alu_c   = diff_w[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOT: alu_res = ~a;
            OP_SHL: begin
                alu_res = a << 1;
                alu_c   = a[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = a >> 1;
                alu_c   = a[0];
            end
            OP_MOV: alu_res = b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        alu_flags        = '0;
        alu_flags[FLG_Z] = (alu_res == '0);
        alu_flags[FLG_N] = alu_res[WIDTH-1];
        alu_flags[FLG_C] = alu_c;
        alu_flags[FLG_V] = alu_v;

        mul_flags        = '0;
        mul_flags[FLG_Z] = (mul_product[WIDTH-1:0] == '0);
        mul_flags[FLG_N] = mul_product[WIDTH-1];
        mul_flags[FLG_C] = |mul_product[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_n   = state;
        rw_n      = RW_READ;
        ri_d_n    = ri_d;
        d_n       = d;
        flags_n   = flags;
        illegal_n = 1'b0;
        mul_dst_n = mul_dst;
        mul_go    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        mul_go    = 1'b1;
                        mul_dst_n = ri_dst;
                        state_n   = ST_MUL;
                    end else if (op > OP_MUL) begin
                        illegal_n = 1'b1;
                    end else begin
                        flags_n = alu_flags;
                        if (op != OP_CMP) begin
                            rw_n   = RW_WRITE;
                            d_n    = alu_res;
                            ri_d_n = ri_dst;
                        end
                    end
                end
            end
            ST_MUL: begin
                // start is deliberately not looked at here: issue while busy is dropped
                if (mul_done) begin
                    rw_n    = RW_WRITE;
                    d_n     = mul_product[WIDTH-1:0];
                    ri_d_n  = mul_dst;
                    flags_n = mul_flags;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            rw      <= RW_READ;
            ri_d    <= '0;
            d       <= '0;
            flags   <= '0;
            illegal <= 1'b0;
            mul_dst <= '0;
        end else begin
            state   <= state_n;
            rw      <= rw_n;
            ri_d    <= ri_d_n;
            d       <= d_n;
            flags   <= flags_n;
            illegal <= illegal_n;
            mul_dst <= mul_dst_n;
        end
    end

    assign busy = (state == ST_MUL);

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - self-checking bench for alu_exec with a write scoreboard
module tb_alu_exec;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] ri_dst;
    logic       busy;
    logic       rw;
    logic [2:0] ri_d;
    logic [7:0] d;
    logic [3:0] flags;
    logic       illegal;

    int n_cmp = 0;
    int n_bad = 0;

    // {ri_d, d, flags}
    logic [14:0] sb_q[$];

    alu_exec #(.WIDTH(8), .RIDX(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .ri_dst  (ri_dst),
        .busy    (busy),
        .rw      (rw),
        .ri_d    (ri_d),
        .d       (d),
        .flags   (flags),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // returns {result, V, N, C, Z}
    function automatic logic [11:0] model(input logic [3:0] mop, input logic [7:0] ma, input logic [7:0] mb);
        int ua = int'(ma);
        int ub = int'(mb);
        int sa = int'($signed(ma));
        int sb = int'($signed(mb));
        int r  = 0;
        int sr = 0;
        logic c = 1'b0;
        logic v = 1'b0;
        logic [7:0] res;
        case (mop)
            4'd0: begin r = ua + ub; c = (r > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
            4'd1, 4'd9: begin r = ua - ub; c = (ua < ub); sr = sa - sb; v = (sr > 127) || (sr < -128); end
            4'd2: r = ua & ub;
            4'd3: r = ua | ub;
            4'd4: r = ua ^ ub;
            4'd5: r = 255 - ua;
            4'd6: begin r = ua * 2; c = ma[7]; end
            4'd7: begin r = ua / 2; c = ma[0]; end
            4'd8: r = ub;
            4'd10: begin r = ua * ub; c = (r > 255); end
            default: r = 0;
        endcase
        res = r[7:0];
        return {res, v, res[7], c, (res == 8'h00)};
    endfunction

    task automatic issue(input logic [3:0] iop, input logic [7:0] ia, input logic [7:0] ib,
                         input logic [2:0] idst, input bit expect_write);
        logic [11:0] m;
        m = model(iop, ia, ib);
        if (expect_write) sb_q.push_back({idst, m});
        op     = iop;
        a      = ia;
        b      = ib;
        ri_dst = idst;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rw) begin
            if (sb_q.size() == 0) begin
                check("unexpected_write", {29'd0, ri_d}, 32'hFFFF_FFFF);
            end else begin
                logic [14:0] e;
                e = sb_q.pop_front();
                check("wr_ri_d",  {29'd0, ri_d},  {29'd0, e[14:12]});
                check("wr_d",     {24'd0, d},     {24'd0, e[11:4]});
                check("wr_flags", {28'd0, flags}, {28'd0, e[3:0]});
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; op = 4'd0; a = 8'd0; b = 8'd0; ri_dst = 3'd0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rw", {31'd0, rw}, 32'd0);
        check("rst_d", {24'd0, d}, 32'd0);
        check("rst_ri_d", {29'd0, ri_d}, 32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // ADD with signed overflow
        issue(4'd0, 8'h7F, 8'h01, 3'd3, 1'b1);
        check("add_rw", {31'd0, rw}, 32'd1);
        check("add_flags", {28'd0, flags}, 32'hC);
        @(posedge clk); #1;
        check("add_rw_fall", {31'd0, rw}, 32'd0);

        // back-to-back SUB, CMP, SHR
        issue(4'd1, 8'h05, 8'h05, 3'd1, 1'b1);
        check("sub_rw", {31'd0, rw}, 32'd1);
        issue(4'd9, 8'h02, 8'h03, 3'd4, 1'b0);
        check("cmp_rw", {31'd0, rw}, 32'd0);
        check("cmp_flags", {28'd0, flags}, 32'h6);
        issue(4'd7, 8'h01, 8'h00, 3'd2, 1'b1);
        check("shr_flags", {28'd0, flags}, 32'h3);
        @(posedge clk); #1;

        // back-to-back random single-cycle ops, rw must stay high throughout
        for (int i = 0; i < 8; i++) begin
            logic [3:0] rop;
            rop = 4'($urandom_range(0, 8));
            issue(rop, 8'($urandom), 8'($urandom), 3'($urandom), 1'b1);
            check("b2b_rw", {31'd0, rw}, 32'd1);
        end
        @(posedge clk); #1;

        // MUL with ignored start pulses while busy
        issue(4'd10, 8'h10, 8'h11, 3'd5, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check("mul_busy", {31'd0, busy}, 32'd1);
            check("mul_no_rw", {31'd0, rw}, 32'd0);
            start = (i == 2 || i == 5);
            op = 4'd0; a = 8'hAA; b = 8'h11; ri_dst = 3'd7;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("mul_done_busy", {31'd0, busy}, 32'd0);
        check("mul_done_rw", {31'd0, rw}, 32'd1);
        check("mul_flags", {28'd0, flags}, 32'h2);
        @(posedge clk); #1;
        check("mul_rw_fall", {31'd0, rw}, 32'd0);

        // reset during MUL iteration 4
        issue(4'd10, 8'hFF, 8'hFF, 3'd6, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_flags", {28'd0, flags}, 32'd0);
        check("abort_rw", {31'd0, rw}, 32'd0);
        repeat (12) @(posedge clk);
        #1;
        issue(4'd0, 8'h03, 8'h04, 3'd6, 1'b1);
        check("post_abort_rw", {31'd0, rw}, 32'd1);
        @(posedge clk); #1;

        // reserved opcode leaves flags alone
        issue(4'd0, 8'h7F, 8'h01, 3'd0, 1'b1);
        issue(4'd12, 8'h00, 8'h00, 3'd2, 1'b0);
        check("ill_pulse", {31'd0, illegal}, 32'd1);
        check("ill_rw", {31'd0, rw}, 32'd0);
        check("ill_flags", {28'd0, flags}, 32'hC);
        check("ill_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check("ill_fall", {31'd0, illegal}, 32'd0);

        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
